// File: rtl/motor_step_gen_if.sv
// Per-axis motor command/status bundle.
// Master drives the move command, slave returns STEP/DIR and status.
interface motor_step_gen_if;
  logic        load;
  logic [31:0] period;
  logic [31:0] steps;
  logic        dir_in;
  logic        ena;
  logic        abort;
  logic        step_o;
  logic        dir_o;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [31:0] steps_left;
  logic [31:0] pos;

  modport master (
    output load,
    output period,
    output steps,
    output dir_in,
    output ena,
    output abort,
    input  step_o,
    input  dir_o,
    input  busy,
    input  done,
    input  overrun,
    input  steps_left,
    input  pos
  );

  modport slave (
    input  load,
    input  period,
    input  steps,
    input  dir_in,
    input  ena,
    input  abort,
    output step_o,
    output dir_o,
    output busy,
    output done,
    output overrun,
    output steps_left,
    output pos
  );
endinterface

// File: rtl/motor_step_gen.sv
// Step/direction pulse generator for one motor axis.
// Tracks remaining steps and signed absolute position.
module motor_step_gen #(
  parameter int unsigned PULSE_W   = 50,
  parameter int unsigned DIR_SETUP = 100
) (
  input logic             clk,
  input logic             sclr,
  motor_step_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DSETUP,
    HIGH,
    LOW,
    FINISH
  } state_t;

  localparam logic [31:0] PW   = 32'(PULSE_W);
  localparam logic [31:0] DS   = 32'(DIR_SETUP);
  localparam logic [31:0] TMIN = 32'(2 * PULSE_W);

  state_t      state;
  state_t      state_n;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic [31:0] teff;
  logic [31:0] teff_n;
  logic [31:0] teff_in;
  logic [31:0] left_q;
  logic [31:0] left_n;
  logic [31:0] lbase;
  logic [31:0] pos_q;
  logic [31:0] pos_n;
  logic        step_q;
  logic        step_n;
  logic        dir_q;
  logic        dir_n;
  logic        busy_q;
  logic        busy_n;
  logic        done_q;
  logic        done_n;
  logic        ovr_q;
  logic        ovr_n;
  logic        abp;
  logic        abp_n;
  logic        go_high;
  logic        fin;

  assign teff_in = (bus.period < TMIN) ? TMIN : bus.period;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state  <= IDLE;
      cnt    <= '0;
      teff   <= '0;
      left_q <= '0;
      pos_q  <= '0;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      abp    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      teff   <= teff_n;
      left_q <= left_n;
      pos_q  <= pos_n;
      step_q <= step_n;
      dir_q  <= dir_n;
      busy_q <= busy_n;
      done_q <= done_n;
      ovr_q  <= ovr_n;
      abp    <= abp_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    teff_n  = teff;
    left_n  = left_q;
    pos_n   = pos_q;
    step_n  = step_q;
    dir_n   = dir_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    ovr_n   = 1'b0;
    abp_n   = abp;
    go_high = 1'b0;
    fin     = 1'b0;
    lbase   = left_q;

    unique case (state)
      IDLE, FINISH: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        if (bus.load) begin
          teff_n = teff_in;
          abp_n  = 1'b0;
          if (bus.steps == '0) begin
            fin = 1'b1;
          end else if (bus.dir_in == dir_q) begin
            go_high = 1'b1;
            lbase   = bus.steps;
          end else begin
            state_n = DSETUP;
            dir_n   = bus.dir_in;
            busy_n  = 1'b1;
            left_n  = bus.steps;
            cnt_n   = DS - 32'd1;
          end
        end
      end

      DSETUP: begin
        if (bus.abort) begin
          fin = 1'b1;
        end else if (cnt == '0) begin
          go_high = 1'b1;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end

      // Abort here only takes effect once the pulse is full width.
      HIGH: begin
        abp_n = abp | bus.abort;
        if (cnt == '0) begin
          step_n = 1'b0;
          if (abp | bus.abort) begin
            fin = 1'b1;
          end else begin
            state_n = LOW;
            cnt_n   = teff - PW - 32'd1;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end

      LOW: begin
        if (bus.abort) begin
          fin = 1'b1;
        end else if (bus.ena) begin
          if (cnt == '0) begin
            if (left_q != '0) begin
              go_high = 1'b1;
            end else begin
              fin = 1'b1;
            end
          end else begin
            cnt_n = cnt - 32'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (bus.load && busy_q) begin
      ovr_n = 1'b1;
    end

    if (go_high) begin
      state_n = HIGH;
      step_n  = 1'b1;
      busy_n  = 1'b1;
      cnt_n   = PW - 32'd1;
      left_n  = lbase - 32'd1;
      pos_n   = dir_n ? pos_q + 32'd1
                      : pos_q - 32'd1;
    end

    if (fin) begin
      state_n = FINISH;
      step_n  = 1'b0;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      abp_n   = 1'b0;
    end
  end

  assign bus.step_o     = step_q;
  assign bus.dir_o      = dir_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.overrun    = ovr_q;
  assign bus.steps_left = left_q;
  assign bus.pos        = pos_q;

endmodule

// File: tb/tb_motor_step_gen.sv
// Directed bench for motor_step_gen.
// Cycle offsets are relative to the cycle load is driven.
module tb_motor_step_gen;

  logic clk = 1'b0;
  logic sclr;
  int   cyc = 0;
  int   t0 = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   rises[$];
  int   widths[$];
  int   dones[$];
  int   ovrs[$];
  int   hcnt = 0;
  logic prev = 1'b0;
  logic busy_seen = 1'b0;
  logic done_busy = 1'b0;

  motor_step_gen_if bus();

  motor_step_gen #(
    .PULSE_W  (50),
    .DIR_SETUP(100)
  ) dut (
    .clk (clk),
    .sclr(sclr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.step_o && !prev) begin
      rises.push_back(cyc);
      hcnt = 0;
    end
    if (bus.step_o) hcnt = hcnt + 1;
    if (!bus.step_o && prev) widths.push_back(hcnt);
    prev = bus.step_o;
    if (bus.done) begin
      dones.push_back(cyc);
      done_busy = bus.busy;
    end
    if (bus.overrun) ovrs.push_back(cyc);
    if (bus.busy) busy_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(int c);
    while (cyc < c) tick();
  endtask

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) exp %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic clr();
    rises.delete();
    widths.delete();
    dones.delete();
    ovrs.delete();
    busy_seen = 1'b0;
  endtask

  task automatic do_load(logic [31:0] p,
                         logic [31:0] s,
                         logic d);
    bus.period = p;
    bus.steps  = s;
    bus.dir_in = d;
    bus.load   = 1'b1;
    t0 = cyc;
    tick();
    bus.load = 1'b0;
  endtask

  function automatic int qat(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    sclr       = 1'b1;
    bus.load   = 1'b0;
    bus.period = '0;
    bus.steps  = '0;
    bus.dir_in = 1'b0;
    bus.ena    = 1'b1;
    bus.abort  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst step_o", 32'(bus.step_o), 0);
    check("rst dir_o", 32'(bus.dir_o), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst overrun", 32'(bus.overrun), 0);
    check("rst steps_left", bus.steps_left, 0);
    check("rst pos", bus.pos, 0);
    tick();
    sclr = 1'b0;
    tick();

    // three steps negative, no direction change
    clr();
    do_load(200, 3, 1'b0);
    @(negedge clk);
    check("t1 busy@1", 32'(bus.busy), 1);
    check("t1 step@1", 32'(bus.step_o), 1);
    run_to(t0 + 700);
    check("t1 nrise", rises.size(), 3);
    check("t1 rise0", qat(rises, 0) - t0, 1);
    check("t1 rise1", qat(rises, 1) - t0, 201);
    check("t1 rise2", qat(rises, 2) - t0, 401);
    check("t1 width0", qat(widths, 0), 50);
    check("t1 width2", qat(widths, 2), 50);
    check("t1 ndone", dones.size(), 1);
    check("t1 done", qat(dones, 0) - t0, 601);
    check("t1 busy@done", 32'(done_busy), 0);
    check("t1 pos", bus.pos, 32'hFFFF_FFFD);
    check("t1 left", bus.steps_left, 0);
    check("t1 busy end", 32'(bus.busy), 0);

    // reverse: direction setup before first rise
    clr();
    do_load(200, 2, 1'b1);
    @(negedge clk);
    check("t2 dir@1", 32'(bus.dir_o), 1);
    check("t2 step@1", 32'(bus.step_o), 0);
    run_to(t0 + 600);
    check("t2 rise0", qat(rises, 0) - t0, 101);
    check("t2 rise1", qat(rises, 1) - t0, 301);
    check("t2 ndone", dones.size(), 1);
    check("t2 done", qat(dones, 0) - t0, 501);
    check("t2 pos", bus.pos, 32'hFFFF_FFFF);

    // short period clamps to 2*PULSE_W
    clr();
    do_load(10, 2, 1'b1);
    run_to(t0 + 300);
    check("t3 nrise", rises.size(), 2);
    check("t3 spacing", qat(rises, 1) - qat(rises, 0), 100);
    check("t3 done", qat(dones, 0) - t0, 201);
    check("t3 pos", bus.pos, 1);

    // zero steps with opposite dir: done only
    clr();
    do_load(200, 0, 1'b0);
    run_to(t0 + 20);
    check("t4 done", qat(dones, 0) - t0, 1);
    check("t4 ndone", dones.size(), 1);
    check("t4 busy seen", 32'(busy_seen), 0);
    check("t4 nrise", rises.size(), 0);
    check("t4 dir_o", 32'(bus.dir_o), 1);
    check("t4 pos", bus.pos, 1);

    // abort in IDLE is ignored
    clr();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    repeat (5) tick();
    check("idle abort done", dones.size(), 0);
    check("idle abort busy", 32'(busy_seen), 0);

    // abort 10 cycles into the 2nd pulse
    clr();
    do_load(200, 5, 1'b1);
    run_to(t0 + 210);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    run_to(t0 + 400);
    check("t5 nrise", rises.size(), 2);
    check("t5 width1", qat(widths, 1), 50);
    check("t5 done", qat(dones, 0) - t0, 251);
    check("t5 ndone", dones.size(), 1);
    check("t5 left", bus.steps_left, 3);
    check("t5 pos", bus.pos, 3);

    // abort during LOW finishes next cycle
    clr();
    do_load(200, 3, 1'b1);
    run_to(t0 + 100);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    run_to(t0 + 300);
    check("abl done", qat(dones, 0) - t0, 101);
    check("abl nrise", rises.size(), 1);
    check("abl left", bus.steps_left, 2);
    check("abl pos", bus.pos, 4);

    // ena pause, overrun, load+abort together, sclr
    clr();
    bus.abort = 1'b1;
    do_load(200, 4, 1'b1);
    bus.abort = 1'b0;
    run_to(t0 + 100);
    bus.ena = 1'b0;
    run_to(t0 + 400);
    bus.ena = 1'b1;
    run_to(t0 + 450);
    bus.period = 10;
    bus.steps  = 99;
    bus.dir_in = 1'b0;
    bus.load   = 1'b1;
    tick();
    bus.load = 1'b0;
    run_to(t0 + 460);
    check("t6 novr", ovrs.size(), 1);
    check("t6 ovr", qat(ovrs, 0) - t0, 451);
    check("t6 left", bus.steps_left, 3);
    check("t6 dir", 32'(bus.dir_o), 1);
    run_to(t0 + 705);
    check("t6 rise0", qat(rises, 0) - t0, 1);
    check("t6 rise1", qat(rises, 1) - t0, 501);
    check("t6 rise2", qat(rises, 2) - t0, 701);
    check("t6 pos", bus.pos, 7);
    check("t6 step hi", 32'(bus.step_o), 1);
    run_to(t0 + 710);
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    check("sclr step_o", 32'(bus.step_o), 0);
    check("sclr pos", bus.pos, 0);
    check("sclr busy", 32'(bus.busy), 0);
    check("sclr left", bus.steps_left, 0);
    check("sclr dir", 32'(bus.dir_o), 0);
    run_to(t0 + 900);
    check("sclr nrise", rises.size(), 3);
    check("sclr ndone", dones.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
